// File: rtl/ram_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
package ram_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Arbiter FSM: accept in IDLE, command on the SRAM in ISSUE, read return in WAIT.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Requester index (0 or 1).
  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and SRAM-side signals of the arbiter, bundled as one interface.
interface ram_arbiter_if
  import ram_pkg::*;
();

  logic  req0;
  logic  req1;
  logic  we0;
  logic  we1;
  addr_t addr0;
  addr_t addr1;
  data_t wdata0;
  data_t wdata1;
  logic  gnt0;
  logic  gnt1;
  logic  rvalid0;
  logic  rvalid1;
  data_t rdata0;
  data_t rdata1;
  logic  mem_wr;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;

  // Traffic sources and SRAM model side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_wr, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational 2-way winner picker.
// RAM_ARB_RR_EN defined: round-robin on contention using the last-granted port.
// RAM_ARB_RR_EN undefined: fixed priority, port 0 wins.
module ram_arb_pick
  import ram_pkg::*;
(
  input  logic [1:0] req,
`ifdef RAM_ARB_RR_EN
  input  port_t      last,
`endif
  output port_t      winner_c
);

  // Winner select; a lone requester always wins.
  always_comb begin
    winner_c = PORT0;
`ifdef RAM_ARB_RR_EN
    if (&req) begin
      winner_c = port_t'(~last);
    end else begin
      winner_c = port_t'(~req[0] & req[1]);
    end
`else
    winner_c = port_t'(~req[0] & req[1]);
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port front end for the 16x8 single-port SRAM: one access in flight,
// registered SRAM command, read data returned to the issuing port.
// Build option: RAM_ARB_RR_EN selects round-robin arbitration (default fixed priority).
module ram_arbiter
  import ram_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  state_t state;
  state_t state_next;

  port_t  winner_c;
  port_t  owner;
  port_t  owner_next;

  logic   any_req;
  logic   win_we;
  addr_t  win_addr;
  data_t  win_wdata;

  logic [1:0] gnt;
  logic [1:0] gnt_next;
  logic [1:0] rvalid;
  logic [1:0] rvalid_next;
  data_t      rdata [2];
  data_t      rdata_next [2];
  logic       mem_wr;
  logic       mem_wr_next;
  addr_t      mem_addr;
  addr_t      mem_addr_next;
  data_t      mem_wdata;
  data_t      mem_wdata_next;

`ifdef RAM_ARB_RR_EN
  port_t ptr;
  port_t ptr_next;
`endif

  assign any_req = bus.req0 | bus.req1;

  ram_arb_pick u_pick (
    .req      ({bus.req1, bus.req0}),
`ifdef RAM_ARB_RR_EN
    .last     (ptr),
`endif
    .winner_c (winner_c)
  );

  // Winning requester's command fields.
  always_comb begin
    win_we    = bus.we0;
    win_addr  = bus.addr0;
    win_wdata = bus.wdata0;
    if (winner_c == PORT1) begin
      win_we    = bus.we1;
      win_addr  = bus.addr1;
      win_wdata = bus.wdata1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; mem_wr high in ISSUE marks a write.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = mem_wr ? IDLE : WAIT;
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the command, grant and read-return registers.
  always_comb begin
    gnt_next       = '0;
    rvalid_next    = '0;
    rdata_next     = rdata;
    mem_wr_next    = 1'b0;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    owner_next     = owner;
`ifdef RAM_ARB_RR_EN
    ptr_next       = ptr;
`endif
    unique case (state)
      IDLE: begin
        if (any_req) begin
          gnt_next[winner_c] = 1'b1;
          mem_wr_next        = win_we;
          mem_addr_next      = win_addr;
          mem_wdata_next     = win_wdata;
`ifdef RAM_ARB_RR_EN
          ptr_next           = winner_c;
`endif
        end
      end
      ISSUE: begin
        if (!mem_wr) owner_next = port_t'(gnt[1]);
      end
      WAIT: begin
        rdata_next[owner]  = bus.mem_rdata;
        rvalid_next[owner] = 1'b1;
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      rvalid    <= '0;
      rdata[0]  <= '0;
      rdata[1]  <= '0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= PORT0;
`ifdef RAM_ARB_RR_EN
      ptr       <= PORT1;
`endif
    end else begin
      gnt       <= gnt_next;
      rvalid    <= rvalid_next;
      rdata     <= rdata_next;
      mem_wr    <= mem_wr_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      owner     <= owner_next;
`ifdef RAM_ARB_RR_EN
      ptr       <= ptr_next;
`endif
    end
  end

  assign bus.gnt0      = gnt[0];
  assign bus.gnt1      = gnt[1];
  assign bus.rvalid0   = rvalid[0];
  assign bus.rvalid1   = rvalid[1];
  assign bus.rdata0    = rdata[0];
  assign bus.rdata1    = rdata[1];
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural SRAM and a
// transaction-level reference model (memory image, last grant, held read data).
module tb_ram_arbiter;
  import ram_pkg::*;

  logic clk;
  logic rst_n;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: write on strobe, registered read data.
  data_t sram [16];
  always @(posedge clk) begin
    if (bus.mem_wr) sram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= sram[bus.mem_addr];
  end

  // Reference model state.
  data_t ref_mem [16];
  data_t exp_rdata [2];
  int    last;
  int    n_checks;
  int    n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1);
`ifdef RAM_ARB_RR_EN
    if (r0 && r1) return (last == 0) ? 1 : 0;
`endif
    return r0 ? 0 : 1;
  endfunction

  task automatic model_reset();
    last = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"},      32'(bus.gnt0),      32'd0);
    check({tag, "_gnt1"},      32'(bus.gnt1),      32'd0);
    check({tag, "_rvalid0"},   32'(bus.rvalid0),   32'd0);
    check({tag, "_rvalid1"},   32'(bus.rvalid1),   32'd0);
    check({tag, "_rdata0"},    32'(bus.rdata0),    32'd0);
    check({tag, "_rdata1"},    32'(bus.rdata1),    32'd0);
    check({tag, "_mem_wr"},    32'(bus.mem_wr),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  task automatic drive_idle();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  // One access from an idle arbiter; entered and left on a falling edge.
  task automatic run_txn(input string tag, input bit r0, input bit r1,
                         input bit w0, input bit w1, input addr_t a0, input addr_t a1,
                         input data_t d0, input data_t d1);
    int    w;
    bit    we;
    addr_t a;
    data_t d;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    w  = pick(r0, r1);
    we = (w == 1) ? w1 : w0;
    a  = (w == 1) ? a1 : a0;
    d  = (w == 1) ? d1 : d0;
    @(negedge clk);
    check({tag, "_gnt0"},      32'(bus.gnt0),      32'(w == 0));
    check({tag, "_gnt1"},      32'(bus.gnt1),      32'(w == 1));
    check({tag, "_mem_wr"},    32'(bus.mem_wr),    32'(we));
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'(a));
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(d));
    last = w;
    if (we) ref_mem[a] = d;
    drive_idle();
    @(negedge clk);
    check({tag, "_gnt_pulse"},  32'(bus.gnt0 | bus.gnt1), 32'd0);
    check({tag, "_wr_pulse"},   32'(bus.mem_wr),          32'd0);
    check({tag, "_addr_hold"},  32'(bus.mem_addr),        32'(a));
    check({tag, "_no_rvalid"},  32'(bus.rvalid0 | bus.rvalid1), 32'd0);
    if (!we) begin
      exp_rdata[w] = ref_mem[a];
      @(negedge clk);
      check({tag, "_rvalid0"}, 32'(bus.rvalid0), 32'(w == 0));
      check({tag, "_rvalid1"}, 32'(bus.rvalid1), 32'(w == 1));
      check({tag, "_rdata0"},  32'(bus.rdata0),  32'(exp_rdata[0]));
      check({tag, "_rdata1"},  32'(bus.rdata1),  32'(exp_rdata[1]));
      @(negedge clk);
      check({tag, "_rvalid_pulse"}, 32'(bus.rvalid0 | bus.rvalid1), 32'd0);
    end
  endtask

  // Reset asserted while an access is in ISSUE (write) or WAIT (read).
  task automatic reset_mid(input string tag, input bit in_wait);
    bus.req0 = 1'b1; bus.we0 = ~in_wait; bus.addr0 = 4'h7; bus.wdata0 = 8'hC3;
    bus.req1 = 1'b0;
    @(negedge clk);
    check({tag, "_gnt0"}, 32'(bus.gnt0), 32'd1);
    drive_idle();
    if (in_wait) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check({tag, "_no_rvalid"}, 32'(bus.rvalid0 | bus.rvalid1), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_post_idle"}, 32'(bus.gnt0 | bus.gnt1 | bus.mem_wr), 32'd0);
  endtask

  // Both ports held as writers for four grants.
  task automatic contention();
    int w;
    int waited;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h1; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'h2; bus.wdata1 = 8'h22;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      @(negedge clk);
      while (!bus.gnt0 && !bus.gnt1 && waited < 4) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.gnt0 && !bus.gnt1) begin
        check($sformatf("cont_timeout%0d", g), 32'd0, 32'd1);
      end else begin
        w = pick(1'b1, 1'b1);
        check($sformatf("cont_gnt%0d", g), 32'(bus.gnt1), 32'(w == 1));
        last = w;
        if (w == 1) ref_mem[4'h2] = 8'h22;
        else        ref_mem[4'h1] = 8'h11;
      end
    end
    drive_idle();
    @(negedge clk);
    check("cont_done", 32'(bus.gnt0 | bus.gnt1), 32'd0);
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit r0;
    bit r1;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    rst_n = 1'b0;
    drive_idle();
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;

    // Reset held with random inputs.
    repeat (4) begin
      @(negedge clk);
      bus.req0 = 1'($urandom); bus.req1 = 1'($urandom);
      bus.we0 = 1'($urandom);  bus.we1 = 1'($urandom);
      bus.addr0 = 4'($urandom); bus.addr1 = 4'($urandom);
      bus.wdata0 = 8'($urandom); bus.wdata1 = 8'($urandom);
      #1;
      check_all_zero("rst");
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_idle_wr",  32'(bus.mem_wr), 32'd0);
      check("rst_idle_gnt", 32'(bus.gnt0 | bus.gnt1), 32'd0);
    end

    // Directed cases.
    run_txn("wr0",      1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 8'hA5, 8'h00);
    run_txn("rd1",      1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h3, 8'h00, 8'h00);
    contention();
    run_txn("wr_f",     1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 8'h5A, 8'h00);
    run_txn("rd_f",     1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 8'h00, 8'h00);
    run_txn("rd_0",     1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00);
    reset_mid("rst_iss", 1'b0);
    reset_mid("rst_wait", 1'b1);
    run_txn("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 4'h0, 8'h00, 8'h00);
    run_txn("both_rd",  1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'hF, 8'h00, 8'h00);

    // Random accesses, possibly contending, with idle gaps.
    for (int n = 0; n < 60; n++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      run_txn($sformatf("rnd%0d", n), r0, r1, 1'($urandom), 1'($urandom),
              4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        check("gap_no_gnt", 32'(bus.gnt0 | bus.gnt1 | bus.mem_wr), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port front end for the 16x8 single-port SRAM. It accepts read/write requests from two requesters and picks one per access. It drives the SRAM's `wr`/`addr`/`wdata` command and returns captured `rdata` to the requester that issued the read. It sits between the SRAM and the two traffic sources, so the SRAM keeps a single master.

## Interface
Parameters:
- `ADDR_W`, 4: SRAM address width.
- `DATA_W`, 8: SRAM data width.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req0`/`req1`, input, 1: requester i has an access pending.
- `we0`/`we1`, input, 1: 1 = write, 0 = read; qualified by `reqi`.
- `addr0`/`addr1`, input, ADDR_W: access address.
- `wdata0`/`wdata1`, input, DATA_W: write data.
- `gnt0`/`gnt1`, output, 1: one-cycle pulse; request accepted.
- `rvalid0`/`rvalid1`, output, 1: one-cycle pulse; `rdatai` is valid.
- `rdata0`/`rdata1`, output, DATA_W: read data, held until the next read for that port.
- `mem_wr`, output, 1: SRAM write strobe.
- `mem_addr`, output, ADDR_W: SRAM address.
- `mem_wdata`, output, DATA_W: SRAM write data.
- `mem_rdata`, input, DATA_W: SRAM read data, registered in the SRAM and valid the cycle after the address is sampled.

## Operation
- FSM states are IDLE, ISSUE and WAIT. Reset puts the FSM in IDLE.
- **IDLE:** if any `reqi` is high at the edge, the arbiter picks a winner and does the following at that same edge:
  - registers `mem_addr`, `mem_wdata` and `mem_wr = wei` from the winner;
  - sets `gnti = 1`;
  - moves to ISSUE.
- **ISSUE:** the SRAM samples the command at the ending edge. At that edge:
  - `gnt` and `mem_wr` clear;
  - a write goes to IDLE;
  - a read goes to WAIT and records the owner.
- **WAIT:** at the ending edge the arbiter captures `rdata_owner <= mem_rdata`, sets `rvalid_owner = 1` for one cycle, and goes to IDLE.
- Requester rules:
  - keep `reqi`, `wei`, `addri`, `wdatai` stable until `gnti` is seen;
  - a request still high in the cycle after `gnti` is a new request.
- Requests are not sampled in ISSUE or WAIT, so there is at most one access in flight.
- `mem_addr` and `mem_wdata` hold their last value outside ISSUE. `mem_wr` is high only in ISSUE, and only for writes.
- Arbitration when both requests are high is set by the configuration macro (see Configuration).
- A read after a write to the same address returns the new data, because accesses are strictly serialized.

## Timing
- Reset values:
  - all outputs are 0: `gnt*`, `rvalid*`, `rdata*`, `mem_wr`, `mem_addr`, `mem_wdata`;
  - FSM is in IDLE;
  - the round-robin pointer favours port 0.
- Latency, with the request sampled at edge E0:
  - `gnt` and the SRAM command are visible E0 to E1;
  - read data is captured at E2, and `rvalid` is high E2 to E3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Reset mid-operation (`rst_n` low in ISSUE or WAIT):
  - the access is abandoned;
  - no `rvalid` is issued;
  - `mem_wr` drops immediately (asynchronous).
- A request that drops before its grant is not serviced.
- Addresses use the full ADDR_W width, with no wrap logic; address 4'hF is legal.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin arbitration.
  - A one-bit pointer records the last granted port.
  - On a simultaneous request, the other port wins.
  - With a single requester, that requester wins regardless of the pointer.
- `RAM_ARB_RR_EN` undefined: fixed priority; port 0 always wins, and no pointer flop is built.

## Structure
- The shared package `ram_pkg` holds:
  - `ADDR_W` and `DATA_W` constants;
  - the FSM state enum typedef (IDLE/ISSUE/WAIT);
  - the port-index typedef.
- One natural sub-module, `ram_arb_pick`: a combinational 2-way picker that takes the requests and the pointer and returns the winner index, containing the macro-dependent logic.
- The FSM, the command registers and the read-return registers live in `ram_arbiter`.

## Test plan
- **Reset:** hold `rst_n` low with random inputs -> every output stays 0; after release with no requests, `mem_wr` stays 0.
- **Single write:** `req0`, `we0 = 1`, `addr0 = 4'h3`, `wdata0 = 8'hA5` -> next cycle has `gnt0 = 1`, `mem_wr = 1`, `mem_addr = 3`, `mem_wdata = A5`, each for exactly one cycle.
- **Read back:** then `req1`, `we1 = 0`, `addr1 = 4'h3` -> `gnt1` pulse, and 2 cycles later `rvalid1 = 1` with `rdata1 = 8'hA5`; `rvalid0` stays 0.
- **Contention:** `req0` and `req1` both held high as writes for 4 grants -> grant order 0,1,0,1 with `RAM_ARB_RR_EN`; 0,0,0,0 without it.
- **Reset mid-read:** pull `rst_n` low during WAIT -> no `rvalid`; all outputs are 0; the next request is serviced normally.
- **Address edge:** write `8'h5A` at `4'hF`, then read `4'hF` -> `rdata = 8'h5A`; `4'h0` is unchanged.
